mem_access_unit: RTL

Load/store front end that sits directly upstream of the word-addressed data memory in the MIPS datapath. Accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests from the MEM stage. Drives the memory's word address, write data and 3-bit memory-control bus. Sub-word stores are done as read-modify-write. Returns sign- or zero-extended load data with a one-cycle response pulse and stall-friendly ready.

---
 rtl/mips_mem_pkg.sv | 22 ++
 rtl/mem_lane_align.sv | 46 ++++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory access path: request sizes,
// memory-control bit positions and the access FSM states.
package mips_mem_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int MC_READ  = 2;
   localparam int MC_WRITE = 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_RESP} mem_state_e;

   // Size 11 is reserved and handled as a word, so bit1 alone selects word rules.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      if (size[1])
         return off != 2'b00;
      else if (size == SZ_HALF)
         return off[0];
      else
         return 1'b0;
   endfunction
endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: extracts/extends a load lane from a memory word
// and merges a right-justified byte/half into a word for read-modify-write.
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   input  logic [15:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (offset)
         2'd0:    byte_lane = word[31:24];
         2'd1:    byte_lane = word[23:16];
         2'd2:    byte_lane = word[15:8];
         default: byte_lane = word[7:0];
      endcase
      half_lane = offset[1] ? word[15:0] : word[31:16];

      if (size[1])
         load_data = word;
      else if (size == SZ_HALF)
         load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      else
         load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};

      store_word = word;
      if (size == SZ_HALF) begin
         if (offset[1]) store_word[15:0]  = wdata;
         else           store_word[31:16] = wdata;
      end else if (size == SZ_BYTE) begin
         case (offset)
            2'd0:    store_word[31:24] = wdata[7:0];
            2'd1:    store_word[23:16] = wdata[7:0];
            2'd2:    store_word[15:8]  = wdata[7:0];
            default: store_word[7:0]   = wdata[7:0];
         endcase
      end
   end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-addressed data memory. Sub-word stores
// are read-modify-write; every output is a flop so the memory sees stable
// control from posedge to posedge.
module mem_access_unit
   import mips_mem_pkg::*;
#(
   parameter int WORD_IDX_W = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misaligned,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic [2:0]  mem_ctrl,
   input  logic [31:0] mem_read_data
);
   mem_state_e  state_q, state_d;
   logic        we_q, we_d, uns_q, uns_d;
   logic [1:0]  size_q, size_d, off_q, off_d;
   logic [15:0] wdata_q, wdata_d;
   logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
   logic        misaligned_q, misaligned_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [31:0] mem_address_q, mem_address_d, mem_write_data_q, mem_write_data_d;
   logic [2:0]  mem_ctrl_q, mem_ctrl_d;
   logic [31:0] load_data, store_word;

   // Address bits above the word index are dropped, so accesses wrap.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:WORD_IDX_W+2];

   mem_lane_align u_align (
      .word        (mem_read_data),
      .offset      (off_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .store_word  (store_word)
   );

   always_comb begin
      state_d          = state_q;
      we_d             = we_q;
      uns_d            = uns_q;
      size_d           = size_q;
      off_d            = off_q;
      wdata_d          = wdata_q;
      misaligned_d     = misaligned_q;
      resp_rdata_d     = resp_rdata_q;
      mem_address_d    = mem_address_q;
      mem_write_data_d = mem_write_data_q;

      case (state_q)
         ST_IDLE: if (req_valid) begin
            we_d          = req_we;
            uns_d         = req_unsigned;
            size_d        = req_size;
            off_d         = req_addr[1:0];
            wdata_d       = req_wdata[15:0];
            mem_address_d = {{(32-WORD_IDX_W){1'b0}}, req_addr[WORD_IDX_W+1:2]};
            if (is_misaligned(req_size, req_addr[1:0])) begin
               misaligned_d = 1'b1;
               resp_rdata_d = '0;
               state_d      = ST_RESP;
            end else if (req_we && req_size[1]) begin
               mem_write_data_d = req_wdata;
               state_d          = ST_WR;
            end else begin
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            if (we_q) begin
               mem_write_data_d = store_word;
               state_d          = ST_WR;
            end else begin
               resp_rdata_d = load_data;
               misaligned_d = 1'b0;
               state_d      = ST_RESP;
            end
         end
         ST_WR: begin
            resp_rdata_d = '0;
            misaligned_d = 1'b0;
            state_d      = ST_RESP;
         end
         default: state_d = ST_IDLE;
      endcase

      // Handshake and memory strobes are decoded from the next state so they
      // are registered alongside it.
      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
      mem_ctrl_d   = '0;
      mem_ctrl_d[MC_READ]  = (state_d == ST_RD);
      mem_ctrl_d[MC_WRITE] = (state_d == ST_WR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         we_q             <= 1'b0;
         uns_q            <= 1'b0;
         size_q           <= SZ_BYTE;
         off_q            <= 2'b00;
         wdata_q          <= '0;
         req_ready_q      <= 1'b1;
         resp_valid_q     <= 1'b0;
         misaligned_q     <= 1'b0;
         resp_rdata_q     <= '0;
         mem_address_q    <= '0;
         mem_write_data_q <= '0;
         mem_ctrl_q       <= '0;
      end else begin
         state_q          <= state_d;
         we_q             <= we_d;
         uns_q            <= uns_d;
         size_q           <= size_d;
         off_q            <= off_d;
         wdata_q          <= wdata_d;
         req_ready_q      <= req_ready_d;
         resp_valid_q     <= resp_valid_d;
         misaligned_q     <= misaligned_d;
         resp_rdata_q     <= resp_rdata_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
         mem_ctrl_q       <= mem_ctrl_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign resp_valid     = resp_valid_q;
   assign misaligned     = misaligned_q;
   assign resp_rdata     = resp_rdata_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;
   assign mem_ctrl       = mem_ctrl_q;
endmodule
